dct_transpose_buffer: RTL and testbench
=======================================

Name: dct_transpose_buffer

Overview:
- 8x8 transpose memory between the row-pass 1-D DCT and the column-pass 1-D DCT of the 2-D DCT encoder.
- Accepts one row of 8 signed 10-bit row-DCT coefficients per handshake.
- After 8 rows have been accepted, emits the block one column per handshake. Each column is already in the parallel form the column-pass DCT expects.
- Data is stored and forwarded unchanged; no arithmetic is performed.

Parameters:
- DW, 10, coefficient width in bits, signed.
- N, 8, block dimension: rows per block and coefficients per row. Fixed at 8 for the encoder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_row holds a valid row.
- in_ready  output  1  buffer can accept a row this cycle.
- in_row  input  N*DW  row coefficients; element k is at bits [k*DW +: DW], signed.
- out_valid  output  1  out_col holds a valid column.
- out_ready  input  1  consumer accepts the column this cycle.
- out_col  output  N*DW  column coefficients; element k is row k of the current column.
- out_col_idx  output  3  index (0..7) of the column currently presented.
- out_last  output  1  high when out_col_idx==7 and out_valid is high.

Behaviour:
- Storage: banks of N x N DW-bit flops. Each bank has a full flag, a write-row counter (wr_row) and a read-column counter (rd_col).
- Write transfer: occurs when in_valid && in_ready. in_row is stored in bank[wr_bank] at row wr_row, and wr_row increments.
  - When wr_row==7: wr_row wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Read transfer: occurs when out_valid && out_ready. rd_col increments.
  - When rd_col==7: rd_col wraps to 0, full[rd_bank] is cleared, and rd_bank toggles.
- in_ready = !full[wr_bank] (combinational from registered state).
- out_valid = full[rd_bank].
- out_col element k = bank[rd_bank][row k][col rd_col]. It is a combinational mux of registered state. out_col_idx = rd_col.
- Latency: out_valid rises the cycle after the row-7 write transfer.
- Stability: out_col and out_col_idx hold stable while out_valid && !out_ready.
- Independence: in_valid does not depend on in_ready, and in_ready does not depend on in_valid. The same holds for the output side.
- Simultaneous events: a write completion and a read completion in the same cycle act on different banks, and both take effect.
  - Setting and clearing the same bank in one cycle cannot occur: a set requires the bank empty, a clear requires it full.
- Partial block: rows already accepted stay pending indefinitely. There is no timeout and no flush.
- Reset (async, any time including mid-block or mid-drain):
  - wr_row=0, rd_col=0, wr_bank=0, rd_bank=0, all full flags=0, all storage=0.
  - Outputs: in_ready=1, out_valid=0, out_col=0, out_col_idx=0, out_last=0.
  - Any in-flight block is discarded.
- Signedness is preserved bit-exactly, including -512 and +511.

Optional Feature:
- Macro: DCT_TRANSPOSE_PINGPONG_EN.
- Defined: two banks. Filling one bank overlaps draining the other. Sustained throughput is one row in and one column out per cycle: 8 cycles per block.
- Undefined: single bank. wr_bank and rd_bank are tied to 0. in_ready is low from the row-7 write until the column-7 read. Throughput is 16 cycles per block.
- Port list and per-transfer behaviour are identical in both builds.

Decomposition:
- dct_pkg holds:
  - constants DCT_DW=10 and DCT_N=8;
  - typedef coef_t (signed [DCT_DW-1:0]);
  - typedef vec_t (array of DCT_N coef_t);
  - pack/unpack helpers between vec_t and the flat N*DW bus.
- Sub-module transpose_bank: one 8x8 coef_t register array with an async reset, a row write port (we, row index, vec_t) and a column read mux (col index -> vec_t). It is instantiated twice with the macro defined and once without.

Test Plan:
- Single block: row r element c = 8r+c (r,c 0..7) with out_ready=1. Expect out_valid one cycle after the 8th write. Column c = {c, 8+c, 16+c, ..., 56+c}, idx 0..7, out_last only on column 7. Then in_ready=1 and out_valid=0.
- Back-to-back blocks (macro on): 4 blocks, in_valid=1 continuously, out_ready=1. Expect in_ready never low and 32 columns out contiguously, with values transposed per block.
- Backpressure: out_ready=0, push rows continuously. Expect in_ready low after 16 rows (macro on) or 8 rows (macro off); no data overwritten. Release out_ready and check both blocks arrive in order.
- Extremes: rows alternating -512 (0x200) and +511 (0x1FF). Expect columns alternate -512/+511 per element, bit-exact.
- Bubbles: random in_valid/out_ready gaps over 10 blocks. Scoreboard the transposed output against a model; out_col must be stable whenever out_valid && !out_ready.
- Reset mid-operation: assert rst after 5 rows of block A, then send block B. Expect immediately after rst out_valid=0, in_ready=1, out_col=0; the output then equals block B only.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared coefficient types and bus pack/unpack helpers for the 2-D DCT transpose path.
package dct_pkg;
  localparam int DCT_DW = 10;
  localparam int DCT_N  = 8;

  typedef logic signed [DCT_DW-1:0] coef_t;
  typedef coef_t [DCT_N-1:0]        vec_t;

  function automatic vec_t unpack_vec(input logic [DCT_N*DCT_DW-1:0] bus);
    vec_t v;
    for (int k = 0; k < DCT_N; k++) v[k] = coef_t'(bus[k*DCT_DW +: DCT_DW]);
    return v;
  endfunction

  function automatic logic [DCT_N*DCT_DW-1:0] pack_vec(input vec_t v);
    logic [DCT_N*DCT_DW-1:0] bus;
    for (int k = 0; k < DCT_N; k++) bus[k*DCT_DW +: DCT_DW] = v[k];
    return bus;
  endfunction
endpackage

// File: rtl/transpose_bank.sv
// One 8x8 coefficient store: rows written whole, columns read through a combinational mux.
module transpose_bank
  import dct_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] wr_row,
  input  vec_t       wr_data,
  input  logic [2:0] rd_col,
  output vec_t       rd_data
);

  vec_t mem [DCT_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DCT_N; r++) mem[r] <= '0;
    end else if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DCT_N; k++) rd_data[k] = mem[k][rd_col];
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Row-in / column-out 8x8 transpose buffer between the two 1-D DCT passes.
// Define DCT_TRANSPOSE_PINGPONG_EN for two banks (fill overlaps drain); default is one bank.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DW = DCT_DW,
  parameter int N  = DCT_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*DW-1:0] out_col,
  output logic [2:0]    out_col_idx,
  output logic          out_last
);

`ifdef DCT_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [1:0] full;
  logic [2:0] wr_row;
  logic [2:0] rd_col;
  logic       wr_bank;
  logic       rd_bank;
  logic       wr_fire;
  logic       rd_fire;
  vec_t       wr_vec;
  vec_t       rd_vec [2];

  assign in_ready    = !full[wr_bank];
  assign out_valid   = full[rd_bank];
  assign wr_fire     = in_valid && in_ready;
  assign rd_fire     = out_valid && out_ready;
  assign wr_vec      = unpack_vec(in_row);
  assign out_col     = pack_vec(rd_vec[rd_bank]);
  assign out_col_idx = rd_col;
  assign out_last    = out_valid && (rd_col == 3'd7);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NB) begin : g_mem
      transpose_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_fire && (wr_bank == 1'(b))),
        .wr_row  (wr_row),
        .wr_data (wr_vec),
        .rd_col  (rd_col),
        .rd_data (rd_vec[b])
      );
    end else begin : g_none
      assign rd_vec[b] = '0;
    end
  end

`ifdef DCT_TRANSPOSE_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (wr_fire && wr_row == 3'd7) wr_bank <= ~wr_bank;
      if (rd_fire && rd_col == 3'd7) rd_bank <= ~rd_bank;
    end
  end
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  // Set and clear never target the same bank in one cycle: set needs it empty, clear needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= '0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      if (wr_fire) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) full[wr_bank] <= 1'b1;
      end
      if (rd_fire) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) full[rd_bank] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench for dct_transpose_buffer: driver pushes expected columns, monitor pops and compares.
module tb_dct_transpose_buffer;

  localparam int DW = 10;
  localparam int N  = 8;
  localparam int BW = N*DW;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
  localparam int CAP_ROWS = 16;
`else
  localparam int CAP_ROWS = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_row = '0;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_col;
  logic [2:0]    out_col_idx;
  logic          out_last;

  dct_transpose_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_col_idx (out_col_idx),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rmode = 0;

  logic [BW-1:0] exp_q [$];
  int            idx_q [$];
  logic [BW-1:0] pend [N];
  int            pcnt = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Row r, column c of each stimulus pattern.
  function automatic logic [DW-1:0] elem(input int kind, input int blk, input int r, input int c);
    int v;
    case (kind)
      0:       v = 8*r + c;
      1:       v = (r % 2 == 0) ? -512 : 511;
      default: v = ((blk*97 + r*13 + c*29) % 1024) - 512;
    endcase
    return DW'(v);
  endfunction

  function automatic logic [BW-1:0] mkrow(input int kind, input int blk, input int r);
    logic [BW-1:0] row;
    row = '0;
    for (int c = 0; c < N; c++) row[c*DW +: DW] = elem(kind, blk, r, c);
    return row;
  endfunction

  task automatic model_push(input logic [BW-1:0] row);
    logic [BW-1:0] col;
    pend[pcnt] = row;
    pcnt++;
    if (pcnt == N) begin
      for (int c = 0; c < N; c++) begin
        col = '0;
        for (int k = 0; k < N; k++) col[k*DW +: DW] = pend[k][c*DW +: DW];
        exp_q.push_back(col);
        idx_q.push_back(c);
      end
      pcnt = 0;
    end
  endtask

  task automatic try_row(input logic [BW-1:0] row, output bit acc);
    in_valid = 1'b1;
    in_row   = row;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) model_push(row);
  endtask

  task automatic send_row(input logic [BW-1:0] row);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      try_row(row, acc);
      n++;
    end
    if (!acc) chk("send_row_timeout", 1, 0);
  endtask

  task automatic send_block(input int kind, input int blk);
    for (int r = 0; r < N; r++) send_row(mkrow(kind, blk, r));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", BW'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // out_ready driver: 0 = hold off, 1 = always accept, 2 = random stalls
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops on each output transfer, checks stability across stalls
  initial begin
    logic [BW-1:0] hcol;
    logic [2:0]    hidx;
    logic [BW-1:0] ecol;
    int            eidx;
    bit            hold;
    hold = 1'b0;
    hcol = '0;
    hidx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("stall_valid", BW'(out_valid), 1);
          chk("stall_col", out_col, hcol);
          chk("stall_idx", BW'(out_col_idx), BW'(hidx));
        end
        if (out_valid) begin
          if (out_ready) begin
            hold = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_col", out_col, '0);
              chk("unexpected_out", 1, 0);
            end else begin
              ecol = exp_q.pop_front();
              eidx = idx_q.pop_front();
              chk("col_data", out_col, ecol);
              chk("col_idx", BW'(out_col_idx), BW'(eidx));
              chk("col_last", BW'(out_last), BW'(eidx == 7));
            end
          end else begin
            hold = 1'b1;
            hcol = out_col;
            hidx = out_col_idx;
          end
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cnt;
    int lows;

    // Reset state
    rmode = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", BW'(in_ready), 1);
    chk("rst_out_valid", BW'(out_valid), 0);
    chk("rst_out_col", out_col, '0);
    chk("rst_out_idx", BW'(out_col_idx), 0);
    chk("rst_out_last", BW'(out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    gap(2);

    // Single block, latency and idle state afterwards
    for (int r = 0; r < N - 1; r++) send_row(mkrow(0, 0, r));
    @(negedge clk);
    chk("pre_last_row_valid", BW'(out_valid), 0);
    @(posedge clk);
    #1;
    send_row(mkrow(0, 0, 7));
    @(negedge clk);
    chk("latency_valid", BW'(out_valid), 1);
    chk("first_col", out_col, {10'd56, 10'd48, 10'd40, 10'd32, 10'd24, 10'd16, 10'd8, 10'd0});
    wait_drain();
    @(negedge clk);
    chk("idle_in_ready", BW'(in_ready), 1);
    chk("idle_out_valid", BW'(out_valid), 0);
    @(posedge clk);
    #1;

`ifdef DCT_TRANSPOSE_PINGPONG_EN
    // Back-to-back blocks: one row per cycle, no input stall, contiguous output
    lows = 0;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < N; r++) begin
        try_row(mkrow(2, 10 + b, r), acc);
        if (!acc) begin
          lows++;
          send_row(mkrow(2, 10 + b, r));
        end
      end
    end
    chk("b2b_in_ready_lows", BW'(lows), 0);
    chk("b2b_pending_cols", BW'(exp_q.size()), 8);
    wait_drain();
`endif

    // Backpressure: capacity then ordered release
    rmode = 0;
    gap(2);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      try_row(mkrow(2, 20 + cnt / N, cnt % N), acc);
      if (acc) cnt++;
    end
    chk("bp_rows_accepted", BW'(cnt), BW'(CAP_ROWS));
    @(negedge clk);
    chk("bp_in_ready_low", BW'(in_ready), 0);
    @(posedge clk);
    #1;
    rmode = 1;
    wait_drain();

    // Extremes: -512 / +511 alternating rows
    send_block(1, 0);
    @(negedge clk);
    chk("extreme_col0", out_col,
        {10'h1FF, 10'h200, 10'h1FF, 10'h200, 10'h1FF, 10'h200, 10'h1FF, 10'h200});
    @(posedge clk);
    #1;
    wait_drain();

    // Bubbles on both sides
    rmode = 2;
    for (int b = 0; b < 10; b++) begin
      for (int r = 0; r < N; r++) begin
        gap($urandom_range(0, 2));
        send_row(mkrow(2, 30 + b, r));
      end
    end
    wait_drain();
    rmode = 1;
    gap(2);

    // Reset mid-block: partial block A discarded, block B only
    for (int r = 0; r < 5; r++) send_row(mkrow(0, 0, r));
    #2;
    rst = 1'b1;
    pcnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", BW'(out_valid), 0);
    chk("midrst_in_ready", BW'(in_ready), 1);
    chk("midrst_out_col", out_col, '0);
    chk("midrst_out_idx", BW'(out_col_idx), 0);
    @(posedge clk);
    #1;
    send_block(2, 55);
    wait_drain();
    @(negedge clk);
    chk("end_out_valid", BW'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
